// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory loader
package imem_pkg;

    localparam int LEN_W          = 16;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_FLUSH,
        S_DONE,
        S_ERROR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and instruction-memory write port out
interface imem_loader_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = 8
) ();

    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;

    // Host/memory side: supplies bytes, observes writes
    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    // Loader side: consumes bytes, drives writes
    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

endinterface

// File: rtl/word_packer.sv
// rtl/word_packer.sv - packs four big-endian bytes into one 32-bit word
module word_packer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              byte_en_i,
    input  logic [7:0]        byte_data_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o
);

    logic [1:0]          idx_q, idx_d;
    logic [WORD_W-9:0]   shift_q, shift_d;

    // Byte index and shift register advance on each accepted byte; clear wins
    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        if (clear_i) begin
            idx_d   = '0;
            shift_d = '0;
        end else if (byte_en_i) begin
            idx_d   = idx_q + 2'd1;
            shift_d = {shift_q[WORD_W-17:0], byte_data_i};
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // The fourth byte completes the word combinationally so the top can register it
    assign word_valid_o = byte_en_i && !clear_i && (idx_q == 2'(BYTES_PER_WORD - 1));
    assign word_o       = {shift_q, byte_data_i};

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed boot loader that fills instruction memory
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    imem_loader_if.slave     bus,
    output logic             cpu_hold,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_loaded
);

    // Largest legal LEN is the full memory capacity; one extra bit holds 2^ADDR_W
    localparam logic [LEN_W:0] CAPACITY = (LEN_W + 1)'(1) << ADDR_W;

    loader_state_t     state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  widx_q, widx_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LEN_W-1:0]  wl_q, wl_d;

    logic              ready_c;
    logic              pack_clear;
    logic              pack_en;
    logic              word_valid;
    logic [WORD_W-1:0] word;
    logic [LEN_W-1:0]  len_full;

    // Only DATA feeds the packer; ready is always high there, so valid alone means accept
    assign pack_en  = (state_q == S_DATA) && bus.byte_valid;
    assign len_full = {len_q[LEN_W-1:8], bus.byte_data};

    word_packer u_packer (
        .clk          (clk),
        .rst          (reset),
        .clear_i      (pack_clear),
        .byte_en_i    (pack_en),
        .byte_data_i  (bus.byte_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    // Next-state, memory-port and counter logic
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        widx_d      = widx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wl_d        = wl_q;
        pack_clear  = 1'b0;
        ready_c     = 1'b0;

        if (mem_we_q && (wl_q != {LEN_W{1'b1}})) begin
            wl_d = wl_q + 1'b1;
        end

        case (state_q)
            S_LEN_HI: begin
                ready_c = 1'b1;
                if (bus.byte_valid) begin
                    len_d[LEN_W-1:8] = bus.byte_data;
                    state_d          = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                ready_c = 1'b1;
                if (bus.byte_valid) begin
                    len_d[7:0] = bus.byte_data;
                    if (len_full == '0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, len_full} > CAPACITY) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d    = S_DATA;
                        widx_d     = '0;
                        pack_clear = 1'b1;
                    end
                end
            end
            S_DATA: begin
                ready_c = 1'b1;
                if (word_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = widx_q[ADDR_W-1:0];
                    mem_wdata_d = word;
                    widx_d      = widx_q + 1'b1;
                    if (widx_q == len_q - 1'b1) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_LEN_HI;
                    len_d      = '0;
                    widx_d     = '0;
                    wl_d       = '0;
                    pack_clear = 1'b1;
                end
            end
            default: begin
                state_d = S_LEN_HI;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_LEN_HI;
            len_q       <= '0;
            widx_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wl_q        <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            widx_q      <= widx_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wl_q        <= wl_d;
        end
    end

    assign bus.byte_ready = ready_c;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

    // CPU is released only once the final write has left the port
    assign cpu_hold     = (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERROR);
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;
    import imem_pkg::*;

    localparam int ADDR_W = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          we_total = 0;
    logic [31:0] exp_words[$];
    int          got_addr[$];
    logic [31:0] got_data[$];

    // Write-port monitor: every cycle with mem_we high is one write
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            got_addr.push_back(int'(bus.mem_addr));
            got_data.push_back(bus.mem_wdata);
            we_total++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        n = 0;
        while (bus.byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check("ready_timeout", 32'(bus.byte_ready), 32'd1);
            bus.byte_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.byte_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit with_byte);
        @(negedge clk);
        start = 1'b1;
        if (with_byte) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = 8'h5A;
        end
        @(posedge clk);
        #1;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
    endtask

    task automatic fill_random(input int len);
        exp_words.delete();
        for (int i = 0; i < len; i++) exp_words.push_back($urandom);
    endtask

    // Streams LEN then exp_words; expected writes are word i at address i
    task automatic load_program(input int len, input int gap_at, input int gap_pct);
        logic [15:0] l;
        logic [31:0] w;
        l = 16'(len);
        got_addr.delete();
        got_data.delete();
        send_byte(l[15:8]);
        send_byte(l[7:0]);
        for (int i = 0; i < len; i++) begin
            w = exp_words[i];
            for (int k = 0; k < 4; k++) begin
                if (i * 4 + k == gap_at) repeat (3) @(posedge clk);
                if (int'($urandom_range(99, 0)) < gap_pct)
                    repeat ($urandom_range(3, 1)) @(posedge clk);
                send_byte(w[31 - 8 * k -: 8]);
            end
        end
        check("last_we", 32'(bus.mem_we), 32'd1);
        check("last_addr", 32'(bus.mem_addr), 32'(len - 1));
        check("done_before_flush", 32'(done), 32'd0);
        check("hold_before_flush", 32'(cpu_hold), 32'd1);
        idle(1);
        check("done_rise", 32'(done), 32'd1);
        check("hold_fall", 32'(cpu_hold), 32'd0);
        check("ready_in_done", 32'(bus.byte_ready), 32'd0);
        check("we_after_flush", 32'(bus.mem_we), 32'd0);
        check("words_loaded", 32'(words_loaded), 32'(len));
        check("write_count", 32'(got_addr.size()), 32'(len));
        for (int i = 0; i < len && i < got_addr.size(); i++) begin
            check("write_addr", 32'(got_addr[i]), 32'(i));
            check("write_data", got_data[i], exp_words[i]);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(bus.byte_ready), 32'd1);
        check({tag, "_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_wl"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        int w0;
        int len;
        reset          = 1'b1;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        idle(3);
        check_reset_values("rst");
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        check_reset_values("post_rst");

        // Directed two-word program, no gaps
        exp_words.delete();
        exp_words.push_back(32'h20080005);
        exp_words.push_back(32'hAC080000);
        load_program(2, -1, 0);

        pulse_start(1'b0);
        check("restart_ready", 32'(bus.byte_ready), 32'd1);
        check("restart_wl", 32'(words_loaded), 32'd0);
        check("restart_hold", 32'(cpu_hold), 32'd1);

        // Same program with a 3-cycle valid gap mid-word
        load_program(2, 2, 0);

        // Start collides with a valid byte: byte must not be consumed
        pulse_start(1'b1);
        check("start_byte_ready", 32'(bus.byte_ready), 32'd1);

        // Oversized length goes to ERROR with no writes
        w0 = we_total;
        send_byte(8'h01);
        send_byte(8'h01);
        check("err_flag", 32'(error), 32'd1);
        check("err_hold", 32'(cpu_hold), 32'd1);
        check("err_ready", 32'(bus.byte_ready), 32'd0);
        check("err_done", 32'(done), 32'd0);
        idle(5);
        check("err_no_writes", 32'(we_total), 32'(w0));
        check("err_sticky", 32'(error), 32'd1);
        pulse_start(1'b0);
        check("err_restart_ready", 32'(bus.byte_ready), 32'd1);
        check("err_restart_flag", 32'(error), 32'd0);

        // Zero-length program finishes immediately
        w0 = we_total;
        send_byte(8'h00);
        send_byte(8'h00);
        check("len0_done", 32'(done), 32'd1);
        check("len0_hold", 32'(cpu_hold), 32'd0);
        check("len0_wl", 32'(words_loaded), 32'd0);
        idle(2);
        check("len0_no_writes", 32'(we_total), 32'(w0));
        pulse_start(1'b0);
        fill_random(1);
        load_program(1, -1, 30);

        // Randomised lengths and gaps
        for (int r = 0; r < 3; r++) begin
            pulse_start(1'b0);
            len = int'($urandom_range(24, 1));
            fill_random(len);
            load_program(len, -1, 25);
        end

        // Full capacity
        pulse_start(1'b0);
        fill_random(256);
        load_program(256, -1, 10);

        // Reset in the middle of a three-word load
        pulse_start(1'b0);
        fill_random(3);
        send_byte(8'h00);
        send_byte(8'h03);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] w;
            w = exp_words[i / 4];
            send_byte(w[31 - 8 * (i % 4) -: 8]);
        end
        w0 = we_total;
        reset = 1'b1;
        #1;
        check_reset_values("mid_rst");
        idle(2);
        check("mid_rst_no_writes", 32'(we_total), 32'(w0));
        @(negedge clk);
        reset = 1'b0;
        idle(2);
        check("post_mid_rst_no_writes", 32'(we_total), 32'(w0));
        fill_random(3);
        load_program(3, -1, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global cycle bound so the run always ends
    initial begin
        #400000;
        n_fail++;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
    end

endmodule
